// File: rtl/config_loader.sv
// Streams WORD-wide words into a staging image, commits it atomically to c.
// Optional trailing XOR check word: define CONFIG_LOADER_CHECKSUM_EN.
module config_loader #(
  parameter int CFG_BITS = 248,
  parameter int WORD     = 8,
  localparam int NWORDS  = (CFG_BITS + WORD - 1) / WORD,
  localparam int CNT_W   = $clog2(NWORDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [WORD-1:0]     cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [CFG_BITS-1:0] c
);

  localparam int SW = NWORDS * WORD;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMMIT,
    DONE,
    ERROR
`ifdef CONFIG_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SW-1:0]       stage_q;
  logic [CFG_BITS-1:0] c_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WORD-1:0]     sum_q;
  logic                err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      c_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else if (cfg_start && state_q != COMMIT) begin
      // restart beats a word presented in the same cycle
      state_q <= LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        LOAD: begin
          if (cfg_valid) begin
            stage_q[WORD*int'(cnt_q) +: WORD] <= cfg_data;
            cnt_q <= cnt_q + 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            sum_q <= sum_q ^ cfg_data;
            if (cnt_q == LAST) state_q <= CHECK;
`else
            if (cnt_q == LAST) begin
              state_q <= COMMIT;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
            end
`endif
          end
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        CHECK: begin
          if (cfg_valid) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            if (cfg_data == sum_q) begin
              state_q <= COMMIT;
            end else begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        COMMIT: begin
          c_q     <= stage_q[CFG_BITS-1:0];
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
  assign c         = c_q;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: default 248-bit instance plus a 20-bit instance
// for the partial-final-word case.
module tb_config_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, valid;
  logic [7:0]   data;
  logic         ready, busy, done, err;
  logic [247:0] c;

  logic         s_start, s_valid;
  logic [7:0]   s_data;
  logic         s_ready, s_busy, s_done, s_err;
  logic [19:0]  s_c;

  int checks = 0;
  int errors = 0;

  logic [7:0]   img_q[$];
  logic [247:0] exp_c = '0;

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [7:0]  w2;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  config_loader u_dut (
    .clk(clk), .rst(rst), .cfg_start(start), .cfg_data(data),
    .cfg_valid(valid), .cfg_ready(ready), .cfg_busy(busy),
    .cfg_done(done), .cfg_err(err), .c(c)
  );

  config_loader #(.CFG_BITS(20), .WORD(8)) u_small (
    .clk(clk), .rst(rst), .cfg_start(s_start), .cfg_data(s_data),
    .cfg_valid(s_valid), .cfg_ready(s_ready), .cfg_busy(s_busy),
    .cfg_done(s_done), .cfg_err(s_err), .c(s_c)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkb(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [247:0] got,
                      input logic [247:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [247:0] model_img(input logic [7:0] q[$]);
    logic [255:0] acc = '0;
    for (int k = 0; k < q.size() && k < 31; k++)
      acc = acc | (256'(q[k]) << (8 * k));
    return acc[247:0];
  endfunction

  function automatic logic [7:0] model_xor(input logic [7:0] q[$]);
    logic [7:0] x = '0;
    foreach (q[k]) x = x ^ q[k];
    return x;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
  endtask

  // gap < 0 picks a random gap per word; flip corrupts the check word
  task automatic load_img(input bit do_start, input int gap,
                          input logic [7:0] flip);
    logic [247:0] prev_c = exp_c;
    int g;
    if (do_start) pulse_start();
    foreach (img_q[k]) begin
      data  = img_q[k];
      valid = 1'b1;
      wait_ready();
      tick();
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (k != img_q.size() - 1 && g > 0) begin
        valid = 1'b0;
        repeat (g) begin
          tick();
          chkb("busy_gap", busy, 1'b1);
        end
      end
    end
`ifdef CONFIG_LOADER_CHECKSUM_EN
    data  = model_xor(img_q) ^ flip;
    valid = 1'b1;
    wait_ready();
    tick();
`endif
    valid = 1'b0;
    chkv("c_hold_pre", c, prev_c);
    chkb("done_pre", done, 1'b0);
    tick();
    if (flip == 8'h00) begin
      exp_c = model_img(img_q);
      chkv("c_commit", c, exp_c);
      chkb("done", done, 1'b1);
      chkb("err_clr", err, 1'b0);
    end else begin
      chkv("c_kept_err", c, prev_c);
      chkb("err", err, 1'b1);
      chkb("done_err", done, 1'b0);
    end
    chkb("busy_end", busy, 1'b0);
    chkb("ready_end", ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; valid = 1'b0; data = '0;
    s_start = 1'b0; s_valid = 1'b0; s_data = '0;

    tbl[0] = '{8'h12, 8'h34, 8'hF5, 20'h53412};
    tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 20'hFFFFF};
    tbl[2] = '{8'h00, 8'h00, 8'h0F, 20'hF0000};
    tbl[3] = '{8'hAB, 8'hCD, 8'hE1, 20'h1CDAB};
    tbl[4] = '{8'h00, 8'hFF, 8'h00, 20'h0FF00};

    repeat (2) tick();
    chkv("rst_c", c, '0);
    chkb("rst_ready", ready, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) tick();
    chkb("idle_ready", ready, 1'b0);
    chkb("idle_busy", busy, 1'b0);
    chkb("idle_err", err, 1'b0);

    // full load 0x00..0x1E, back to back
    img_q.delete();
    for (int i = 0; i < 31; i++) img_q.push_back(8'(i));
    load_img(1'b1, 0, 8'h00);
    chkv("c_byte0", 248'(c[7:0]), 248'(8'h00));
    chkv("c_byte30", 248'(c[247:240]), 248'(8'h1E));

`ifdef CONFIG_LOADER_CHECKSUM_EN
    // check word 0x00 instead of 0x1F: rejected, c keeps the image
    load_img(1'b1, 0, 8'h1F);
`endif

    // words presented outside LOAD are ignored
    data = 8'h77;
    valid = 1'b1;
    repeat (3) tick();
    chkb("no_ready_idle", ready, 1'b0);
    chkv("c_after_ignored", c, exp_c);
    valid = 1'b0;

    // gaps of 3 cycles between words
    img_q.delete();
    repeat (31) img_q.push_back(8'hA5);
    load_img(1'b1, 3, 8'h00);
    chkv("c_a5", c, {31{8'hA5}});

    // restart mid-load, restart wins over a same-cycle word
    img_q.delete();
    repeat (31) img_q.push_back(8'hFF);
    load_img(1'b1, 0, 8'h00);
    pulse_start();
    data = 8'h3C;
    valid = 1'b1;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chkv("c_restart_hold", c, {248{1'b1}});
    chkb("restart_busy", busy, 1'b1);
    chkb("restart_done", done, 1'b0);
    img_q.delete();
    repeat (31) img_q.push_back(8'h3C);
    load_img(1'b0, 0, 8'h00);
    chkv("c_3c", c, {31{8'h3C}});

    // random images, random gaps
    for (int r = 0; r < 4; r++) begin
      img_q.delete();
      repeat (31) img_q.push_back(8'($urandom));
      load_img(1'b1, -1, 8'h00);
    end

    // partial final word, 20-bit instance
    for (int i = 0; i < 5; i++) begin
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      s_valid = 1'b1;
      s_data = tbl[i].w0; tick();
      s_data = tbl[i].w1; tick();
      s_data = tbl[i].w2; tick();
`ifdef CONFIG_LOADER_CHECKSUM_EN
      s_data = tbl[i].w0 ^ tbl[i].w1 ^ tbl[i].w2;
      tick();
`endif
      s_valid = 1'b0;
      tick();
      chkv("small_c", 248'(s_c), 248'(tbl[i].exp));
      chkb("small_done", s_done, 1'b1);
    end

    // async reset mid-load
    pulse_start();
    data = 8'h5A;
    valid = 1'b1;
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    chkv("mid_rst_c", c, '0);
    chkb("mid_rst_ready", ready, 1'b0);
    chkb("mid_rst_done", done, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    valid = 1'b0;
    #2 rst = 1'b0;
    repeat (3) tick();
    chkb("post_rst_ready", ready, 1'b0);
    chkv("post_rst_c", c, '0);
    exp_c = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
